// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Purpose:
//   Merges an instruction-fetch port and a load/store port onto a single
//   shared memory request/response interface with split address and data
//   phases. Load/store requests have priority over fetches. Once a request
//   has been presented and not yet accepted, the same master stays granted
//   until the memory accepts it. An in-order FIFO of master IDs records who
//   owns each accepted request. Each response is routed back to that owner.
//
// Ports:
//   clk, resetn           - clock (rising edge) and async active-low reset
//   inst_req/inst_addr    - fetch request (read-only, 4 bytes)
//   inst_addr_ok          - fetch request accepted this cycle
//   inst_data_ok/_rdata   - fetch data returned this cycle
//   data_req/_wr/_size/
//   _wstrb/_addr/_wdata   - load/store request
//   data_addr_ok          - load/store request accepted this cycle
//   data_data_ok/_rdata   - load/store response this cycle
//   m_req/_wr/_size/
//   _wstrb/_addr/_wdata   - shared memory request (all zero when idle)
//   m_addr_ok/_data_ok/
//   m_rdata               - shared memory response
//
// Parameter:
//   DEPTH - maximum accepted requests still awaiting their data phase
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_e;

    state_e             state_q, state_d;

    logic [DEPTH-1:0]   id_q, id_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               grant_i;
    logic               grant_d;
    logic               push;
    logic               pop;
    logic               head_id;

    // Pointer advance that wraps modulo DEPTH, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A presented request that is not accepted locks the
    // grant onto that master until the memory takes it.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d && !m_addr_ok) begin
                    state_d = HOLD_D;
                end else if (grant_i && !m_addr_ok) begin
                    state_d = HOLD_I;
                end
            end
            HOLD_I, HOLD_D: begin
                if (m_addr_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: grant selection and the shared request mux. Selection in
    // IDLE is suppressed when the ID FIFO is full. Gating with resetn keeps
    // the request lines quiet while reset is held even if requests are up.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (count_q < CNT_W'(DEPTH)) begin
                        if (data_req) begin
                            grant_d = 1'b1;
                        end else if (inst_req) begin
                            grant_i = 1'b1;
                        end
                    end
                end
                HOLD_I:  grant_i = 1'b1;
                HOLD_D:  grant_d = 1'b1;
                default: ;
            endcase
        end

        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_wstrb = 4'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        if (grant_d) begin
            m_req   = 1'b1;
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end else if (grant_i) begin
            // Fetches are always 4-byte reads.
            m_req   = 1'b1;
            m_size  = 2'd2;
            m_addr  = inst_addr;
        end

        inst_addr_ok = m_req & m_addr_ok & grant_i;
        data_addr_ok = m_req & m_addr_ok & grant_d;
    end

    // -----------------------------------------------------------------------
    // Response routing. A data_ok with nothing outstanding is dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        push         = m_req & m_addr_ok;
        pop          = m_data_ok & (count_q != '0);
        head_id      = id_q[rd_ptr_q];
        inst_data_ok = pop & ~head_id;
        data_data_ok = pop &  head_id;
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
    end

    // -----------------------------------------------------------------------
    // ID FIFO next-state: 0 marks a fetch, 1 a load/store. A full FIFO never
    // sees a push because selection is blocked at count == DEPTH.
    // -----------------------------------------------------------------------
    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            id_d[wr_ptr_q] = grant_d;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // ID FIFO registers. Reset discards any outstanding IDs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Purpose:
//   Directed, table-driven bench for mem_req_arbiter (DEPTH = 4). Each
//   table row is one clock cycle of inputs with the hand-derived grant and
//   response strobes for that cycle. Rows run back to back from reset, so
//   FIFO contents carry over from row to row. Hand-written sequences after
//   the table cover asynchronous reset in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

    localparam logic [31:0] INST_BASE = 32'h1000_0000;
    localparam logic [31:0] DATA_BASE = 32'h2000_0000;

    // Expected grant for a cycle: nobody, fetch port, or load/store port.
    localparam int G_NONE = 0;
    localparam int G_INST = 1;
    localparam int G_DATA = 2;

    typedef struct {
        string name;
        logic  ireq;
        logic  dreq;
        logic  aok;
        logic  dok;
        int    grant;
        logic  idok;
        logic  ddok;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int tests_run;
    int tests_failed;

    vec_t vecs[$];

    mem_req_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic ireq, input logic dreq,
                                input logic aok, input logic dok, input int g,
                                input logic idok, input logic ddok);
        vec_t v;
        v.name  = n;
        v.ireq  = ireq;
        v.dreq  = dreq;
        v.aok   = aok;
        v.dok   = dok;
        v.grant = g;
        v.idok  = idok;
        v.ddok  = ddok;
        return v;
    endfunction

    // Drive one cycle of inputs. Addresses, store data and read data change
    // with the index so stale muxing shows up.
    task automatic apply_stimulus(input logic ireq, input logic dreq, input logic aok,
                                  input logic dok, input int idx);
        inst_req   = ireq;
        data_req   = dreq;
        m_addr_ok  = aok;
        m_data_ok  = dok;
        inst_addr  = INST_BASE + 32'(idx * 4);
        data_addr  = DATA_BASE + 32'(idx * 8);
        data_wr    = idx[0];
        data_size  = 2'(idx % 3);
        data_wstrb = 4'(idx) | 4'b0001;
        data_wdata = 32'hC0DE_0000 + 32'(idx);
        m_rdata    = 32'hA5A5_0000 + 32'(idx);
    endtask

    // Compare every output against values derived from the driven inputs
    // and the expected grant.
    task automatic check_output(input string name, input int g,
                                input logic exp_idok, input logic exp_ddok);
        logic [139:0] act;
        logic [139:0] exp;
        logic         e_req;
        logic         e_wr;
        logic [1:0]   e_size;
        logic [3:0]   e_wstrb;
        logic [31:0]  e_addr;
        logic [31:0]  e_wdata;

        e_req = 1'b0; e_wr = 1'b0; e_size = 2'd0; e_wstrb = 4'd0;
        e_addr = 32'd0; e_wdata = 32'd0;
        if (g == G_DATA) begin
            e_req = 1'b1; e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb;
            e_addr = data_addr; e_wdata = data_wdata;
        end else if (g == G_INST) begin
            e_req = 1'b1; e_size = 2'd2; e_addr = inst_addr;
        end

        act = {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
               inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
               inst_rdata, data_rdata};
        exp = {e_req, e_wr, e_size, e_wstrb, e_addr, e_wdata,
               (g == G_INST) && m_addr_ok, (g == G_DATA) && m_addr_ok,
               exp_idok, exp_ddok, m_rdata, m_rdata};

        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        //            name          ireq dreq aok  dok  grant   idok ddok
        vecs.push_back(mk("idle",       0, 0, 0, 0, G_NONE, 0, 0));
        vecs.push_back(mk("both_pri",   1, 1, 1, 0, G_DATA, 0, 0)); // cnt1 [D]
        vecs.push_back(mk("inst_next",  1, 0, 1, 0, G_INST, 0, 0)); // cnt2 [D,I]
        vecs.push_back(mk("pop_d",      0, 0, 0, 1, G_NONE, 0, 1)); // cnt1
        vecs.push_back(mk("pop_i",      0, 0, 0, 1, G_NONE, 1, 0)); // cnt0
        vecs.push_back(mk("empty_dok",  0, 0, 0, 1, G_NONE, 0, 0));
        vecs.push_back(mk("hold_i0",    1, 0, 0, 0, G_INST, 0, 0));
        vecs.push_back(mk("hold_i1",    1, 1, 0, 0, G_INST, 0, 0));
        vecs.push_back(mk("hold_i2",    1, 1, 0, 0, G_INST, 0, 0));
        vecs.push_back(mk("hold_i3",    1, 1, 1, 0, G_INST, 0, 0)); // cnt1 [I]
        vecs.push_back(mk("push_pop",   0, 1, 1, 1, G_DATA, 1, 0)); // cnt1 [D]
        vecs.push_back(mk("pop_d2",     0, 0, 0, 1, G_NONE, 0, 1)); // cnt0
        vecs.push_back(mk("hold_d0",    1, 1, 0, 0, G_DATA, 0, 0));
        vecs.push_back(mk("hold_d1",    1, 0, 0, 0, G_DATA, 0, 0));
        vecs.push_back(mk("hold_d2",    1, 1, 1, 0, G_DATA, 0, 0)); // cnt1 [D]
        vecs.push_back(mk("fill_i",     1, 0, 1, 0, G_INST, 0, 0)); // cnt2
        vecs.push_back(mk("fill_d",     0, 1, 1, 0, G_DATA, 0, 0)); // cnt3
        vecs.push_back(mk("fill_i2",    1, 0, 1, 0, G_INST, 0, 0)); // cnt4 [D,I,D,I]
        vecs.push_back(mk("full",       1, 1, 1, 0, G_NONE, 0, 0));
        vecs.push_back(mk("full_pop",   1, 1, 1, 1, G_NONE, 0, 1)); // cnt3
        vecs.push_back(mk("refill",     1, 0, 1, 0, G_INST, 0, 0)); // cnt4 [I,D,I,I]
        vecs.push_back(mk("full2",      1, 0, 1, 0, G_NONE, 0, 0));
        vecs.push_back(mk("drain_i",    0, 0, 0, 1, G_NONE, 1, 0));
        vecs.push_back(mk("drain_d",    0, 0, 0, 1, G_NONE, 0, 1));
        vecs.push_back(mk("drain_i2",   0, 0, 0, 1, G_NONE, 1, 0));
        vecs.push_back(mk("drain_i3",   0, 0, 0, 1, G_NONE, 1, 0)); // cnt0
        vecs.push_back(mk("empty_dok2", 0, 0, 0, 1, G_NONE, 0, 0));
        vecs.push_back(mk("acc_i",      1, 0, 1, 0, G_INST, 0, 0));
        vecs.push_back(mk("acc_d",      0, 1, 1, 0, G_DATA, 0, 0));
        vecs.push_back(mk("acc_i2",     1, 0, 1, 0, G_INST, 0, 0));
        vecs.push_back(mk("acc_d2",     0, 1, 1, 0, G_DATA, 0, 0)); // cnt4 [I,D,I,D]
        vecs.push_back(mk("fifth",      1, 1, 1, 0, G_NONE, 0, 0));
        vecs.push_back(mk("order_i",    0, 0, 0, 1, G_NONE, 1, 0));
        vecs.push_back(mk("order_d",    0, 0, 0, 1, G_NONE, 0, 1));
        vecs.push_back(mk("order_i2",   0, 0, 0, 1, G_NONE, 1, 0));
        vecs.push_back(mk("order_d2",   0, 0, 0, 1, G_NONE, 0, 1)); // cnt0

        // Outputs while reset is held.
        #2;
        check_output("reset_state", G_NONE, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok, i + 1);
            #2;
            check_output(vecs[i].name, vecs[i].grant, vecs[i].idok, vecs[i].ddok);
        end

        // Reset pulse with two requests outstanding and a fetch pending.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 100);
        #2;
        check_output("rst_acc_i", G_INST, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 101);
        #2;
        check_output("rst_acc_d", G_DATA, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 102);
        #1;
        resetn = 1'b0;
        #1;
        check_output("rst_async", G_NONE, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 103);
        #2;
        check_output("rst_drop_dok", G_NONE, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 104);
        #2;
        check_output("rst_drop_dok2", G_NONE, 1'b0, 1'b0);

        // Reset in the middle of a hold: the FSM must come back in IDLE, so
        // the load/store port wins selection afterwards.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 105);
        #2;
        check_output("hold_before_rst", G_INST, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 106);
        #2;
        check_output("hold_still_i", G_INST, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        check_output("hold_rst_async", G_NONE, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 107);
        #2;
        check_output("after_rst_data", G_DATA, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 108);
        #2;
        check_output("after_rst_pop_d", G_NONE, 1'b0, 1'b1);

        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
